// File: rtl/strobe_to_axis_packer.sv
// Packs strobed I/Q samples into a small FIFO and emits them as an AXI-Stream with tlast every spp beats.
// Optional macro STROBE_TO_AXIS_DROP_CNT_EN adds a saturating drop_count output.
module strobe_to_axis_packer #(
    parameter int WIDTH       = 16,
    parameter int FIFO_AWIDTH = 4,
    parameter int SPP_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [SPP_WIDTH-1:0]   spp,
    input  logic [WIDTH-1:0]       in_i,
    input  logic [WIDTH-1:0]       in_q,
    input  logic                   strobe_in,
    output logic [2*WIDTH-1:0]     o_tdata,
    output logic                   o_tlast,
    output logic                   o_tvalid,
    input  logic                   o_tready,
    output logic                   overflow,
    output logic [FIFO_AWIDTH:0]   fifo_level
`ifdef STROBE_TO_AXIS_DROP_CNT_EN
    ,
    output logic [15:0]            drop_count
`endif
);

    localparam int                   DEPTH   = 1 << FIFO_AWIDTH;
    localparam logic [FIFO_AWIDTH-1:0] PTR_ONE = 1;
    localparam logic [FIFO_AWIDTH:0]   LVL_ONE = 1;
    localparam logic [SPP_WIDTH-1:0]   SPP_ONE = 1;

    logic [2*WIDTH-1:0]     mem_q [DEPTH];
    logic [FIFO_AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AWIDTH:0]   level_q, level_d;
    logic                   tvalid_q, tvalid_d;
    logic [SPP_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [SPP_WIDTH-1:0]   spp_l_q, spp_l_d;
    logic                   ovf_q, ovf_d;

    logic                   full;
    logic                   handshake;
    logic                   wr_en;
    logic                   drop;
    logic [SPP_WIDTH-1:0]   spp_eff_live;
    logic [SPP_WIDTH-1:0]   spp_eff_lat;
    logic [SPP_WIDTH-1:0]   last_idx;

    // AXI-Stream: a beat transfers on any cycle with o_tvalid & o_tready; while
    // o_tvalid & !o_tready, o_tdata and o_tlast hold. strobe_in has no back-pressure.
    assign full      = level_q[FIFO_AWIDTH];
    assign handshake = tvalid_q & o_tready;
    assign wr_en     = strobe_in & (~full | handshake);
    assign drop      = strobe_in & full & ~handshake;

    // First beat of a packet frames against the live spp; later beats use the latched copy.
    assign spp_eff_live = (spp == '0) ? SPP_ONE : spp;
    assign spp_eff_lat  = (spp_l_q == '0) ? SPP_ONE : spp_l_q;
    assign last_idx     = (pkt_cnt_q == '0) ? (spp_eff_live - SPP_ONE) : (spp_eff_lat - SPP_ONE);

    assign o_tdata    = mem_q[rd_ptr_q];
    assign o_tlast    = tvalid_q & (pkt_cnt_q == last_idx);
    assign o_tvalid   = tvalid_q;
    assign overflow   = ovf_q;
    assign fifo_level = level_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        pkt_cnt_d = pkt_cnt_q;
        spp_l_d   = spp_l_q;
        ovf_d     = ovf_q;

        if (clear) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            pkt_cnt_d = '0;
            spp_l_d   = SPP_ONE;
            ovf_d     = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (handshake) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                if (pkt_cnt_q == '0) begin
                    spp_l_d = spp;
                end
                if (o_tlast) begin
                    pkt_cnt_d = '0;
                end else begin
                    pkt_cnt_d = pkt_cnt_q + SPP_ONE;
                end
            end
            case ({wr_en, handshake})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
        tvalid_d = (level_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            tvalid_q  <= 1'b0;
            pkt_cnt_q <= '0;
            spp_l_q   <= SPP_ONE;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            tvalid_q  <= tvalid_d;
            pkt_cnt_q <= pkt_cnt_d;
            spp_l_q   <= spp_l_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage is not reset: every entry is written before o_tvalid can expose it.
    always_ff @(posedge clk) begin
        if (!reset && !clear && wr_en) begin
            mem_q[wr_ptr_q] <= {in_i, in_q};
        end
    end

`ifdef STROBE_TO_AXIS_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_strobe_to_axis_packer.sv
// Bench for strobe_to_axis_packer: queue-based reference model, directed scenarios plus a randomized run.
module tb_strobe_to_axis_packer;
  localparam int W = 16;
  localparam int AW = 4;
  localparam int SW = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset, clear, strobe_in, o_tready;
  logic [SW-1:0] spp;
  logic [W-1:0] in_i, in_q;
  logic [2*W-1:0] o_tdata;
  logic o_tlast, o_tvalid, overflow;
  logic [AW:0] fifo_level;
`ifdef STROBE_TO_AXIS_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  strobe_to_axis_packer #(.WIDTH(W), .FIFO_AWIDTH(AW), .SPP_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .spp(spp),
    .in_i(in_i), .in_q(in_q), .strobe_in(strobe_in),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .overflow(overflow), .fifo_level(fifo_level)
`ifdef STROBE_TO_AXIS_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model and scoreboard
  logic [2*W-1:0] m_fifo[$];
  bit m_ovf;
  int m_drops, m_beat, m_spp_l;
  logic [2*W:0] exp_q[$];
  logic [2*W:0] act_q[$];
  int bubbles;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic model_reset();
    m_fifo.delete();
    m_ovf = 0;
    m_drops = 0;
    m_beat = 0;
    m_spp_l = 1;
  endtask

  // Drive one clock of stimulus; record the observed beat and advance the model.
  task automatic cycle(input bit stb, input logic [W-1:0] i, input logic [W-1:0] q, input bit rdy);
    bit hs, last;
    int eff;
    strobe_in = stb; in_i = i; in_q = q; o_tready = rdy;
    #1;
    if (o_tvalid && o_tready) act_q.push_back({o_tlast, o_tdata});
    if (rdy && m_fifo.size() != 0 && !o_tvalid) bubbles++;
    hs = (m_fifo.size() != 0) && rdy;
    if (hs) begin
      if (m_beat == 0) m_spp_l = int'(spp);
      eff = (m_spp_l == 0) ? 1 : m_spp_l;
      last = (m_beat == eff - 1);
      exp_q.push_back({last, m_fifo.pop_front()});
      m_beat = last ? 0 : m_beat + 1;
    end
    if (stb) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back({i, q});
      else begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && m_fifo.size() != 0; k++) cycle(0, '0, '0, 1);
    cycle(0, '0, '0, 1);
    cycle(0, '0, '0, 1);
  endtask

  task automatic do_clear();
    strobe_in = 1; in_i = 16'hDEAD; in_q = 16'hBEEF; o_tready = 1; clear = 1;
    @(posedge clk);
    @(negedge clk);
    clear = 0; strobe_in = 0; o_tready = 0;
    model_reset();
  endtask

  task automatic test_reset();
    n_cmp++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", o_tvalid); end
    n_cmp++; if (o_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", o_tlast); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_single();
    spp = 4;
    act_q.delete(); exp_q.delete();
    cycle(1, 16'h1234, 16'hABCD, 1);
    n_cmp++; if (o_tvalid !== 1'b1) begin n_fail++; $display("FAIL single_tvalid: got %b want 1", o_tvalid); end
    n_cmp++; if (o_tdata !== 32'h1234ABCD) begin n_fail++; $display("FAIL single_tdata: got %h want 1234abcd", o_tdata); end
    n_cmp++; if (o_tlast !== 1'b0) begin n_fail++; $display("FAIL single_tlast: got %b want 0", o_tlast); end
    cycle(0, '0, '0, 1);
    n_cmp++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_tvalid_after: got %b want 0", o_tvalid); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL single_level_after: got %0d want 0", fifo_level); end
  endtask

  task automatic test_framing();
    logic [15:0] nv;
    spp = 4;
    do_clear();
    act_q.delete(); exp_q.delete(); bubbles = 0;
    for (int n = 0; n < 12; n++) begin
      nv = 16'(n);
      cycle(1, nv, ~nv, 1);
    end
    drain();
    n_cmp++; if (act_q.size() != 12) begin n_fail++; $display("FAIL framing_count: got %0d want 12", act_q.size()); end
    for (int k = 0; k < 12 && k < act_q.size(); k++) begin
      nv = 16'(k);
      n_cmp++;
      if (act_q[k] !== {(k % 4 == 3), nv, ~nv}) begin
        n_fail++; $display("FAIL framing_beat%0d: got %h want %h", k, act_q[k], {(k % 4 == 3), nv, ~nv});
      end
    end
    n_cmp++; if (bubbles != 0) begin n_fail++; $display("FAIL framing_bubbles: got %0d want 0", bubbles); end
  endtask

  task automatic test_overflow();
    do_clear();
    spp = 4;
    act_q.delete(); exp_q.delete();
    for (int n = 0; n < 20; n++) cycle(1, 16'($urandom), 16'($urandom), 0);
    n_cmp++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL ovf_level: got %0d want 16", fifo_level); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (o_tvalid !== 1'b1) begin n_fail++; $display("FAIL ovf_tvalid: got %b want 1", o_tvalid); end
`ifdef STROBE_TO_AXIS_DROP_CNT_EN
    n_cmp++; if (drop_count !== 16'd4) begin n_fail++; $display("FAIL ovf_drop_count: got %0d want 4", drop_count); end
`endif
    drain();
    n_cmp++; if (act_q.size() != 16) begin n_fail++; $display("FAIL ovf_count: got %0d want 16", act_q.size()); end
    foreach (exp_q[k]) if (k < act_q.size()) begin
      n_cmp++; if (act_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL ovf_beat%0d: got %h want %h", k, act_q[k], exp_q[k]); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_full_simul();
    do_clear();
    spp = 4;
    act_q.delete(); exp_q.delete();
    for (int n = 0; n < 16; n++) cycle(1, 16'(n), 16'h5500, 0);
    cycle(1, 16'hCAFE, 16'hF00D, 1);
    n_cmp++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL simul_level: got %0d want 16", fifo_level); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL simul_overflow: got %b want 0", overflow); end
    drain();
    n_cmp++; if (act_q.size() != 17) begin n_fail++; $display("FAIL simul_count: got %0d want 17", act_q.size()); end
    if (act_q.size() > 16) begin
      n_cmp++; if (act_q[16][2*W-1:0] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL simul_new_sample: got %h want cafef00d", act_q[16][2*W-1:0]); end
    end
    foreach (exp_q[k]) if (k < act_q.size()) begin
      n_cmp++; if (act_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL simul_beat%0d: got %h want %h", k, act_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_spp_edge();
    bit pat[6] = '{0, 0, 0, 1, 0, 1};
    do_clear();
    spp = 0;
    act_q.delete(); exp_q.delete();
    for (int n = 0; n < 5; n++) cycle(1, 16'($urandom), 16'($urandom), 1);
    drain();
    n_cmp++; if (act_q.size() != 5) begin n_fail++; $display("FAIL spp0_count: got %0d want 5", act_q.size()); end
    foreach (act_q[k]) begin
      n_cmp++; if (act_q[k][2*W] !== 1'b1) begin n_fail++; $display("FAIL spp0_tlast%0d: got %b want 1", k, act_q[k][2*W]); end
    end
    spp = 4;
    act_q.delete(); exp_q.delete();
    for (int n = 0; n < 6; n++) begin
      if (n == 3) spp = 2;
      cycle(1, 16'(n), 16'h00AA, 1);
    end
    drain();
    n_cmp++; if (act_q.size() != 6) begin n_fail++; $display("FAIL sppchg_count: got %0d want 6", act_q.size()); end
    for (int k = 0; k < 6 && k < act_q.size(); k++) begin
      n_cmp++; if (act_q[k][2*W] !== pat[k]) begin n_fail++; $display("FAIL sppchg_tlast%0d: got %b want %b", k, act_q[k][2*W], pat[k]); end
    end
  endtask

  task automatic test_clear_mid();
    do_clear();
    spp = 4;
    for (int n = 0; n < 17; n++) cycle(1, 16'($urandom), 16'($urandom), 0);
    for (int n = 0; n < 11; n++) cycle(0, '0, '0, 1);
    o_tready = 0;
    n_cmp++; if (fifo_level !== 5'd5) begin n_fail++; $display("FAIL clr_pre_level: got %0d want 5", fifo_level); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_pre_overflow: got %b want 1", overflow); end
    do_clear();
    n_cmp++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL clr_tvalid: got %b want 0", o_tvalid); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL clr_level: got %0d want 0", fifo_level); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow: got %b want 0", overflow); end
`ifdef STROBE_TO_AXIS_DROP_CNT_EN
    n_cmp++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL clr_drop_count: got %0d want 0", drop_count); end
`endif
    act_q.delete(); exp_q.delete();
    for (int n = 0; n < 4; n++) cycle(1, 16'(n), 16'h0C0C, 1);
    drain();
    n_cmp++; if (act_q.size() != 4) begin n_fail++; $display("FAIL clr_after_count: got %0d want 4", act_q.size()); end
    for (int k = 0; k < 4 && k < act_q.size(); k++) begin
      n_cmp++; if (act_q[k][2*W] !== (k == 3)) begin n_fail++; $display("FAIL clr_after_tlast%0d: got %b want %b", k, act_q[k][2*W], (k == 3)); end
    end
  endtask

  task automatic test_random();
    do_clear();
    act_q.delete(); exp_q.delete();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) spp = 16'($urandom_range(0, 6));
      cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), $urandom_range(0, 2) == 0);
      n_cmp++; if (fifo_level !== 5'(m_fifo.size())) begin n_fail++; $display("FAIL rnd_level@%0d: got %0d want %0d", n, fifo_level, m_fifo.size()); end
      n_cmp++; if (o_tvalid !== (m_fifo.size() != 0)) begin n_fail++; $display("FAIL rnd_tvalid@%0d: got %b want %b", n, o_tvalid, m_fifo.size() != 0); end
      n_cmp++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow@%0d: got %b want %b", n, overflow, m_ovf); end
    end
`ifdef STROBE_TO_AXIS_DROP_CNT_EN
    n_cmp++; if (drop_count !== 16'(m_drops)) begin n_fail++; $display("FAIL rnd_drop_count: got %0d want %0d", drop_count, m_drops); end
`endif
    drain();
    n_cmp++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < act_q.size()) begin
      n_cmp++; if (act_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rnd_beat%0d: got %h want %h", k, act_q[k], exp_q[k]); end
    end
  endtask

  initial begin
    reset = 1; clear = 0; strobe_in = 0; o_tready = 0; spp = 4; in_i = '0; in_q = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
    test_reset();
    test_single();
    test_framing();
    test_overflow();
    test_full_simul();
    test_spp_edge();
    test_clear_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
